// File: rtl/wbu_pkg.sv
// Shared core constants for the write-back unit and its register file.
package wbu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int X0_IDX     = 0;
    localparam int RETIRE_W   = 64;
endpackage

// File: rtl/wbu_regfile.sv
// Architectural register file: x0 hard-wired to zero, two combinational read
// ports that forward the value being written on the same edge.
module wbu_regfile
    import wbu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH     = DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data
);
    localparam int                      NREGS = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] X0  = REG_ADDR_WIDTH'(X0_IDX);

    logic [DATA_WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != X0)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 check takes priority so a discarded x0 write is never forwarded.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == X0) begin
            rs1_data = '0;
        end else if (we && (waddr == rs1_addr)) begin
            rs1_data = wdata;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == X0) begin
            rs2_data = '0;
        end else if (we && (waddr == rs2_addr)) begin
            rs2_data = wdata;
        end
    end
endmodule

// File: rtl/wbu.sv
// Write-back unit: one-entry skid-free pipeline register between memory stage
// and commit, register-file write on commit, and a retired-instruction counter.
module wbu
    import wbu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH     = DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_valid,
    output logic                      m_ready,
    input  logic                      m_regW,
    input  logic [REG_ADDR_WIDTH-1:0] m_regAddr,
    input  logic [DATA_WIDTH-1:0]     m_regData,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic                      c_regW,
    output logic [REG_ADDR_WIDTH-1:0] c_regAddr,
    output logic [DATA_WIDTH-1:0]     c_regData,
    output logic [RETIRE_W-1:0]       retire_cnt
);
    logic                      vld_p1;
    logic                      regw_p1;
    logic [REG_ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0]     data_p1;
    logic                      m_fire;
    logic                      c_fire;

    assign m_ready = !vld_p1 || c_ready;
    assign m_fire  = m_valid && m_ready;
    assign c_fire  = vld_p1 && c_ready;

    // Stage p1: held entry. A new capture on a commit edge replaces the
    // retiring entry directly, so back-to-back results see no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            regw_p1 <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (m_fire) begin
            vld_p1  <= 1'b1;
            regw_p1 <= m_regW;
            addr_p1 <= m_regAddr;
            data_p1 <= m_regData;
        end else if (c_fire) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (c_fire) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign c_valid   = vld_p1;
    assign c_regW    = regw_p1;
    assign c_regAddr = addr_p1;
    assign c_regData = data_p1;

    wbu_regfile #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (c_fire && regw_p1),
        .waddr   (addr_p1),
        .wdata   (data_p1),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data)
    );
endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port m_valid, input, 1, memory stage presents a result.
REQ-006 SHALL have port m_ready, output, 1, wbu accepts the memory-stage result this cycle.
REQ-007 SHALL have port m_regW, input, 1, result writes the register file.
REQ-008 SHALL have port m_regAddr, input, REG_ADDR_WIDTH, destination register index.
REQ-009 SHALL have port m_regData, input, DATA_WIDTH, destination register data.
REQ-010 SHALL have ports rs1_addr and rs2_addr, input, REG_ADDR_WIDTH each, decode read indices.
REQ-011 SHALL have ports rs1_data and rs2_data, output, DATA_WIDTH each, decode read data.
REQ-012 SHALL have port c_valid, output, 1, a held entry is presented for commit.
REQ-013 SHALL have port c_ready, input, 1, commit/difftest consumer accepts the entry.
REQ-014 SHALL have ports c_regW, c_regAddr, c_regData, outputs, widths as REQ-007..009, the held entry.
REQ-015 SHALL have port retire_cnt, output, 64, count of committed entries.

Function
REQ-016 SHALL hold one entry in a pipeline register (valid bit plus regW/regAddr/regData).
REQ-017 SHALL drive m_ready = !c_valid || c_ready, combinationally.
REQ-018 SHALL capture inputs on m_fire = m_valid && m_ready; c_valid rises the next cycle (latency 1).
REQ-019 SHALL define c_fire = c_valid && c_ready; on c_fire without m_fire, c_valid clears next cycle.
REQ-020 SHALL, on simultaneous c_fire and m_fire, retire the old entry and load the new one in the same edge, with no bubble.
REQ-021 SHALL hold c_regW/c_regAddr/c_regData stable while c_valid && !c_ready.
REQ-022 SHALL write the register file at the c_fire edge only when c_regW=1 and c_regAddr!=0.
REQ-023 SHALL keep register x0 reading as zero; writes to x0 are discarded.
REQ-024 SHALL provide combinational reads: rsN_data = 0 if rsN_addr==0; else c_regData if c_fire && c_regW && c_regAddr==rsN_addr (bypass); else the stored value.
REQ-025 SHALL increment retire_cnt by 1 on each c_fire regardless of c_regW; it wraps modulo 2^64.
REQ-026 SHALL ignore m_regW/m_regAddr/m_regData when m_valid=0.

Reset
REQ-027 SHALL, on rst assertion, asynchronously clear c_valid, c_regW, c_regAddr, c_regData, retire_cnt, and all 32 registers to 0.
REQ-028 SHALL, on reset mid-operation, drop any held entry with no register write and no count increment.
REQ-029 SHALL drive m_ready=1 during and immediately after reset.

Structure
REQ-030 SHALL take REG_ADDR_WIDTH, DATA_WIDTH and the x0 index constant from the shared core package.
REQ-031 SHALL implement the register array and bypass read ports as one sub-module, regfile.
REQ-032 SHALL keep the pipeline register, handshake and retire counter in wbu.

Verification
REQ-033 SHALL cover: m_valid=1, regW=1, addr=5, data=0xDEADBEEF, c_ready=1 -> c_valid next cycle; then rs1_addr=5 reads 0xDEADBEEF; retire_cnt=1.
REQ-034 SHALL cover: write addr=0, data=0x1234 -> rs1_data for addr 0 stays 0; retire_cnt still increments.
REQ-035 SHALL cover: c_ready=0 for 3 cycles with an entry held -> m_ready=0, c_reg* stable, no register write; c_ready=1 -> exactly one write.
REQ-036 SHALL cover: back-to-back m_valid with c_ready=1, addrs 1,2,3 -> one commit per cycle, no bubbles, retire_cnt=3.
REQ-037 SHALL cover: during c_fire of addr=7, data=0xA5, rs2_addr=7 -> rs2_data=0xA5 in the same cycle (bypass).
REQ-038 SHALL cover: rst asserted while an entry is held -> c_valid=0 immediately, no write to its register, retire_cnt=0.
